// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mdu_pkg
// Purpose  : Shared encodings for the multiply/divide unit: opcodes, the
//            op-class decode of op[2:1], and the control FSM state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package mdu_pkg;

  // Opcodes: op[0] selects unsigned operands, op[2:1] selects the class
  localparam logic [2:0] c_OP_MULT  = 3'b000;
  localparam logic [2:0] c_OP_MULTU = 3'b001;
  localparam logic [2:0] c_OP_DIV   = 3'b010;
  localparam logic [2:0] c_OP_DIVU  = 3'b011;
  localparam logic [2:0] c_OP_MADD  = 3'b100;
  localparam logic [2:0] c_OP_MADDU = 3'b101;
  localparam logic [2:0] c_OP_MSUB  = 3'b110;
  localparam logic [2:0] c_OP_MSUBU = 3'b111;

  // Op-class decode of op[2:1]
  localparam logic [1:0] c_CLS_MUL = 2'b00;
  localparam logic [1:0] c_CLS_DIV = 2'b01;
  localparam logic [1:0] c_CLS_ADD = 2'b10;
  localparam logic [1:0] c_CLS_SUB = 2'b11;

  // Control FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIN  = 2'd3
  } state_t;

endpackage : mdu_pkg
`default_nettype wire

// File: rtl/div_iter.sv
`default_nettype none
// ============================================================================
// Module   : div_iter
// Purpose  : Radix-2 restoring divider datapath on unsigned magnitudes.
//            One quotient bit per i_step; o_quot_next/o_rem_next expose the
//            values the current step will write so the caller can capture
//            the final result on the same edge as the last step.
// Revision : 1.0 - initial release
// ============================================================================
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_step,
  input  logic             i_clear,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_last,
  output logic [WIDTH-1:0] o_quot_next,
  output logic [WIDTH-1:0] o_rem_next
);

  localparam int                c_CNT_W = $clog2(WIDTH);
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quot;
  logic [WIDTH-1:0]   r_div;
  logic [c_CNT_W-1:0] r_cnt;

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_diff;
  logic           w_fits;

  // Shift the next dividend bit into the partial remainder and trial-subtract
  assign w_shift     = {r_rem, r_quot[WIDTH-1]};
  assign w_diff      = w_shift - {1'b0, r_div};
  assign w_fits      = ~w_diff[WIDTH];
  assign o_rem_next  = w_fits ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign o_quot_next = {r_quot[WIDTH-2:0], w_fits};
  assign o_last      = (r_cnt == c_LAST);

  // Partial remainder, quotient shift register and step counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem  <= '0;
      r_quot <= '0;
      r_div  <= '0;
      r_cnt  <= '0;
    end else if (i_clear) begin
      r_cnt  <= '0;
    end else if (i_load) begin
      r_rem  <= '0;
      r_quot <= i_dividend;
      r_div  <= i_divisor;
      r_cnt  <= '0;
    end else if (i_step) begin
      r_rem  <= o_rem_next;
      r_quot <= o_quot_next;
      r_cnt  <= r_cnt + 1'b1;
    end
  end

endmodule : div_iter
`default_nettype wire

// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : mul_div_unit
// Purpose  : Multi-cycle multiply / multiply-accumulate / divide unit with
//            a {hi,lo} result, flush abort and divide-by-zero flag.
// Revision : 1.0 - initial release
// ============================================================================
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MUL_LATENCY = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   src_a,
  input  logic [WIDTH-1:0]   src_b,
  input  logic [2*WIDTH-1:0] hilo_i,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               div_zero
);

  localparam int                  c_MCNT_W   = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
  localparam logic [c_MCNT_W-1:0] c_MUL_LAST = c_MCNT_W'(MUL_LATENCY - 1);

  state_t r_state;
  state_t w_next;

  logic [1:0]         w_cls;
  logic               w_uns;
  logic               w_is_div;
  logic               w_b_zero;
  logic               w_accept;
  logic               w_mul_last;
  logic               w_div_last;
  logic [2*WIDTH-1:0] w_ext_a;
  logic [2*WIDTH-1:0] w_ext_b;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_acc_val;
  logic [2*WIDTH-1:0] w_mul_out;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH-1:0]   w_quot_next;
  logic [WIDTH-1:0]   w_rem_next;
  logic [WIDTH-1:0]   w_quot_fix;
  logic [WIDTH-1:0]   w_rem_fix;

  logic [2*WIDTH-1:0]  r_prod;
  logic [c_MCNT_W-1:0] r_mul_cnt;
  logic                r_neg_q;
  logic                r_neg_r;

  assign w_cls      = op[2:1];
  assign w_uns      = op[0];
  assign w_is_div   = (w_cls == c_CLS_DIV);
  assign w_b_zero   = (src_b == '0);
  assign w_accept   = start & ~flush & ((r_state == ST_IDLE) | (r_state == ST_FIN));
  assign w_mul_last = (r_state == ST_MUL) & (r_mul_cnt == c_MUL_LAST);

  // Sign- or zero-extend to 2*WIDTH so one truncated multiply serves both
  assign w_ext_a   = {{WIDTH{~w_uns & src_a[WIDTH-1]}}, src_a};
  assign w_ext_b   = {{WIDTH{~w_uns & src_b[WIDTH-1]}}, src_b};
  assign w_prod    = w_ext_a * w_ext_b;
  assign w_acc_val = (w_cls == c_CLS_ADD) ? hilo_i + w_prod :
                     (w_cls == c_CLS_SUB) ? hilo_i - w_prod : w_prod;

  // Signed division works on magnitudes; signs are restored at the end
  assign w_mag_a = (~w_uns & src_a[WIDTH-1]) ? -src_a : src_a;
  assign w_mag_b = (~w_uns & src_b[WIDTH-1]) ? -src_b : src_b;

  assign w_quot_fix = r_neg_q ? -w_quot_next : w_quot_next;
  assign w_rem_fix  = r_neg_r ? -w_rem_next  : w_rem_next;

  assign busy = (r_state == ST_MUL) | (r_state == ST_DIV);
  assign done = (r_state == ST_FIN);

  div_iter #(.WIDTH(WIDTH)) u_div_iter (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_accept & w_is_div & ~w_b_zero),
    .i_step      (r_state == ST_DIV),
    .i_clear     (flush),
    .i_dividend  (w_mag_a),
    .i_divisor   (w_mag_b),
    .o_last      (w_div_last),
    .o_quot_next (w_quot_next),
    .o_rem_next  (w_rem_next)
  );

  // Product delay line: MUL_LATENCY-1 stages behind the registered product
  if (MUL_LATENCY > 1) begin : g_delay
    logic [2*WIDTH-1:0] r_pipe [MUL_LATENCY-1];
    // Shift the product down the line every cycle
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < MUL_LATENCY - 1; i++) r_pipe[i] <= '0;
      end else begin
        r_pipe[0] <= r_prod;
        for (int i = 1; i < MUL_LATENCY - 1; i++) r_pipe[i] <= r_pipe[i-1];
      end
    end
    assign w_mul_out = r_pipe[MUL_LATENCY-2];
  end else begin : g_no_delay
    assign w_mul_out = r_prod;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic; flush overrides everything, start only heard in IDLE/FIN
  always_comb begin
    w_next = r_state;
    if (flush) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE, ST_FIN: begin
          if (!start)        w_next = ST_IDLE;
          else if (!w_is_div) w_next = ST_MUL;
          else if (w_b_zero) w_next = ST_FIN;
          else               w_next = ST_DIV;
        end
        ST_MUL:  if (w_mul_last) w_next = ST_FIN;
        ST_DIV:  if (w_div_last) w_next = ST_FIN;
        default: w_next = ST_IDLE;
      endcase
    end
  end

  // Operand capture on accept and multiply-phase cycle counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prod    <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_mul_cnt <= '0;
    end else if (w_accept) begin
      r_prod    <= w_acc_val;
      r_neg_q   <= ~w_uns & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
      r_neg_r   <= ~w_uns & src_a[WIDTH-1];
      r_mul_cnt <= '0;
    end else if (r_state == ST_MUL) begin
      r_mul_cnt <= r_mul_cnt + 1'b1;
    end
  end

  // Result and flag register: written only on the edge that enters FIN
  always_ff @(posedge clk) begin
    if (rst) begin
      result   <= '0;
      div_zero <= 1'b0;
    end else if (w_accept) begin
      div_zero <= w_is_div & w_b_zero;
      if (w_is_div & w_b_zero) result <= {src_a, {WIDTH{1'b1}}};
    end else if (!flush && w_mul_last) begin
      result <= w_mul_out;
    end else if (!flush && (r_state == ST_DIV) && w_div_last) begin
      result <= {w_rem_fix, w_quot_fix};
    end
  end

endmodule : mul_div_unit
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_div_unit
// Purpose  : Self-checking bench for mul_div_unit (WIDTH=32, MUL_LATENCY=2)
//            against a cycle-count/arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul_div_unit;

  localparam int W = 32;
  localparam int L = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          start = 1'b0;
  logic [2:0]    op = 3'b000;
  logic [W-1:0]  src_a = '0;
  logic [W-1:0]  src_b = '0;
  logic [2*W-1:0] hilo_i = '0;
  logic          busy;
  logic          done;
  logic [2*W-1:0] result;
  logic          div_zero;

  int total = 0;
  int bad = 0;

  mul_div_unit #(.WIDTH(W), .MUL_LATENCY(L)) dut (
    .clk(clk), .rst(rst), .flush(flush), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b), .hilo_i(hilo_i),
    .busy(busy), .done(done), .result(result), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Arithmetic reference: returns {div_zero, result}
  function automatic logic [64:0] ref_calc(input logic [2:0] f_op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [63:0] hilo);
    longint pa, pb, prod;
    int ia, ib;
    logic [31:0] q, rm;
    logic [63:0] r;
    logic dz;
    dz = 1'b0;
    ia = a;
    ib = b;
    pa = f_op[0] ? longint'({32'b0, a}) : longint'(ia);
    pb = f_op[0] ? longint'({32'b0, b}) : longint'(ib);
    prod = pa * pb;
    case (f_op[2:1])
      2'b00: r = prod;
      2'b10: r = hilo + prod;
      2'b11: r = hilo - prod;
      default: begin
        if (b == 0) begin
          dz = 1'b1;
          r = {a, 32'hFFFF_FFFF};
        end else if (f_op[0]) begin
          r = {a % b, a / b};
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          r = {32'h0, 32'h8000_0000};
        end else begin
          q = ia / ib;
          rm = ia % ib;
          r = {rm, q};
        end
      end
    endcase
    return {dz, r};
  endfunction

  function automatic int ref_lat(input logic [2:0] f_op, input logic [31:0] b);
    if (f_op[2:1] == 2'b01) return (b == 0) ? 1 : W + 1;
    return L + 1;
  endfunction

  // Model state: m_k = cycles since accept (0 = nothing pending)
  int          m_k = 0;
  int          m_lat = 0;
  logic [63:0] m_val = '0;
  logic [63:0] m_res = '0;
  logic        m_dz = 1'b0;

  initial begin
    logic [64:0] tmp;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_k = 0; m_res = '0; m_dz = 1'b0;
      end else if (flush) begin
        m_k = 0;
      end else if (start && (m_k == 0 || m_k == m_lat)) begin
        tmp   = ref_calc(op, src_a, src_b, hilo_i);
        m_val = tmp[63:0];
        m_dz  = tmp[64];
        m_lat = ref_lat(op, src_b);
        m_k   = 1;
        if (m_lat == 1) m_res = m_val;
      end else if (m_k > 0) begin
        if (m_k == m_lat) m_k = 0;
        else begin
          m_k++;
          if (m_k == m_lat) m_res = m_val;
        end
      end
    end
  end

  // Compare DUT against the model every cycle
  initial begin
    forever begin
      @(negedge clk);
      chk("busy", 64'(busy), 64'(m_k > 0 && m_k < m_lat));
      chk("done", 64'(done), 64'(m_k > 0 && m_k == m_lat));
      chk("result", result, m_res);
      chk("div_zero", 64'(div_zero), 64'(m_dz));
    end
  end

  // Drive one op right after a negedge, wait for done; optional start poke while busy
  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] h, input logic [63:0] exp_res,
                        input logic exp_dz, input int exp_lat, input int exp_busy, input int poke_at);
    int n, nb;
    start = 1'b1; op = o; src_a = a; src_b = b; hilo_i = h;
    @(negedge clk);
    start = 1'b0;
    n = 1; nb = 0;
    while (!done && n < 100) begin
      if (busy) nb++;
      if (n == poke_at) begin
        start = 1'b1; op = 3'b001; src_a = 32'd9; src_b = 32'd9;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk({name, " latency"}, 64'(n), 64'(exp_lat));
    chk({name, " result"}, result, exp_res);
    chk({name, " div_zero"}, 64'(div_zero), 64'(exp_dz));
    if (exp_busy >= 0) chk({name, " busy cycles"}, 64'(nb), 64'(exp_busy));
  endtask

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("reset busy", 64'(busy), 64'h0);
    chk("reset done", 64'(done), 64'h0);
    chk("reset result", result, 64'h0);
    chk("reset div_zero", 64'(div_zero), 64'h0);
    rst = 1'b0;
    @(negedge clk);

    run_op("MULT", 3'b000, 32'hFFFF_FFFF, 32'h2, 64'h0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 3, 2, 0);
    run_op("DIVU", 3'b011, 32'd100, 32'd7, 64'h0, 64'h0000_0002_0000_000E, 1'b0, 33, 32, 5);
    run_op("DIV neg", 3'b010, 32'hFFFF_FFF9, 32'd2, 64'h0, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 33, 32, 0);
    run_op("DIV min", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0, 64'h0000_0000_8000_0000, 1'b0, 33, 32, 0);
    run_op("DIV zero", 3'b010, 32'h1234, 32'h0, 64'h0, 64'h0000_1234_FFFF_FFFF, 1'b1, 1, 0, 0);
    run_op("MADD", 3'b100, 32'd3, 32'hFFFF_FFFF, 64'h10, 64'hD, 1'b0, 3, 2, 0);
    run_op("MSUBU", 3'b111, 32'd1, 32'd1, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 3, 2, 0);

    // Flush a divide at iteration 10, with a competing start on the same edge
    start = 1'b1; op = 3'b011; src_a = 32'd100; src_b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    flush = 1'b1; start = 1'b1; op = 3'b000; src_a = 32'd3; src_b = 32'd3;
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    chk("flush busy", 64'(busy), 64'h0);
    chk("flush done", 64'(done), 64'h0);
    chk("flush result held", result, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op("MULT after flush", 3'b000, 32'd5, 32'd6, 64'h0, 64'd30, 1'b0, 3, 2, 0);

    // Randomized traffic checked by the model
    for (int i = 0; i < 1500; i++) begin
      rst    = ($urandom_range(0, 199) == 0);
      flush  = ($urandom_range(0, 29) == 0);
      start  = ($urandom_range(0, 2) == 0);
      op     = 3'($urandom_range(0, 7));
      src_a  = pick32();
      src_b  = pick32();
      hilo_i = {$urandom, $urandom};
      @(negedge clk);
    end
    rst = 1'b0; flush = 1'b0; start = 1'b0;
    repeat (40) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_mul_div_unit
`default_nettype wire

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand width in bits (even, >=8).
REQ-002 SHALL have parameter MUL_LATENCY, default 2, meaning multiply/accumulate cycles from accept to done, >=1.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port flush  input  1  abort the current operation.
REQ-006 SHALL have port start  input  1  request a new operation.
REQ-007 SHALL have port op  input  3  operation code: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MADD, 101 MADDU, 110 MSUB, 111 MSUBU.
REQ-008 SHALL have port src_a  input  WIDTH  multiplicand or dividend.
REQ-009 SHALL have port src_b  input  WIDTH  multiplier or divisor.
REQ-010 SHALL have port hilo_i  input  2*WIDTH  accumulator {hi,lo} for MADD/MSUB.
REQ-011 SHALL have port busy  output  1  operation in flight.
REQ-012 SHALL have port done  output  1  single-cycle result-valid pulse.
REQ-013 SHALL have port result  output  2*WIDTH  {hi,lo}.
REQ-014 SHALL have port div_zero  output  1  last division had a zero divisor.

Function
REQ-015 SHALL implement FSM states IDLE, MUL, DIV and FIN.
REQ-016 SHALL accept start only in IDLE or FIN, latching op, src_a, src_b and hilo_i on that edge.
REQ-017 SHALL ignore start while in MUL or DIV, with no queuing.
REQ-018 SHALL move an accepted MULT/MULTU/MADD*/MSUB* to MUL and remain there exactly MUL_LATENCY cycles.
REQ-019 SHALL move an accepted DIV/DIVU with nonzero divisor to DIV and perform WIDTH radix-2 restoring iterations, one per cycle.
REQ-020 SHALL move an accepted DIV/DIVU with src_b==0 directly to FIN, setting div_zero=1, lo=all-ones and hi=src_a.
REQ-021 SHALL hold FIN for exactly one cycle with done=1, then enter IDLE, or enter MUL/DIV/FIN if start is accepted in FIN.
REQ-022 SHALL give done latencies after the accept edge of MUL_LATENCY+1 cycles for multiply, WIDTH+1 for divide and 1 for divide-by-zero.
REQ-023 SHALL assert busy in MUL and DIV and deassert it in IDLE and FIN.
REQ-024 SHALL make result valid from done and hold it until the next done, reset or flush, never changing while busy.
REQ-025 SHALL produce for MULT/MULTU the full 2*WIDTH product, signed or unsigned.
REQ-026 SHALL produce for MADD/MADDU hilo_i + product and for MSUB/MSUBU hilo_i - product, modulo 2^(2*WIDTH), with the product signedness set by op[0].
REQ-027 SHALL produce for DIV/DIVU hi=remainder and lo=quotient.
REQ-028 SHALL, for signed division, divide magnitudes and then give the quotient sign a^b and the remainder the sign of a.
REQ-029 SHALL return for signed MIN/-1 lo=MIN and hi=0, with no flag.
REQ-030 SHALL clear div_zero on each accepted start and update it only at FIN.
REQ-031 SHALL, on flush, go to IDLE on the next edge from any state with done=0, busy=0 and result unchanged.
REQ-032 SHALL let flush win over a simultaneous start.
REQ-033 SHALL suppress a done due in the same cycle as flush.

Reset
REQ-034 SHALL on rst set state=IDLE, busy=0, done=0, result=0, div_zero=0 and iteration counter=0.
REQ-035 SHALL let rst override flush and start and abandon any in-flight operation with no done.

Structure
REQ-036 SHALL place the op encoding, the state encoding and the MUL/DIV/accumulate op-class decode constants in shared package mdu_pkg.
REQ-037 SHALL contain one sub-module, div_iter, holding the WIDTH-step restoring divider datapath (partial remainder, quotient shift register, step counter), driven by the FSM.
REQ-038 SHALL implement the multiply as a registered product plus a MUL_LATENCY-1 stage delay line, with retiming left to synthesis.

Verification (WIDTH=32, MUL_LATENCY=2)
REQ-039 SHALL verify MULT a=0xFFFFFFFF, b=0x00000002 -> result 0xFFFFFFFF_FFFFFFFE, done 3 cycles after accept, busy high for 2 cycles.
REQ-040 SHALL verify DIVU a=100, b=7 -> hi=2, lo=14, done 33 cycles after accept, div_zero=0.
REQ-041 SHALL verify DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; and a=0x80000000, b=-1 -> lo=0x80000000, hi=0.
REQ-042 SHALL verify DIV a=0x1234, b=0 -> done 1 cycle after accept, div_zero=1, lo=0xFFFFFFFF, hi=0x1234.
REQ-043 SHALL verify MADD hilo_i=0x0_00000010, a=3, b=-1 -> 0x0_0000000D; and MSUBU hilo_i=0, a=1, b=1 -> 0xFFFFFFFF_FFFFFFFF.
REQ-044 SHALL verify flush at DIV iteration 10 -> busy=0 next cycle, no done, prior result held, a start one cycle later is accepted and completes normally; a start during busy is ignored.
